// File: rtl/dlx_muldiv.sv
// Iterative 32-bit multiply/divide unit for the DLX pipeline.
// Shift-add multiply and restoring divide on magnitudes, with a fixed 33-cycle latency.
module dlx_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        reg_write,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        div_by_zero,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic        r_neg;
  logic        r_bzero;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic [4:0]  r_rd;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic [31:0] r_result;
  logic [4:0]  r_rd_out;

  logic        w_sgn_in;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_mag_res;
  logic [31:0] w_fixed;

  // op[0]=0 selects the signed variants (MULT, DIV).
  assign w_sgn_in  = ~op[0];
  assign w_a_mag   = (w_sgn_in && a_in[31]) ? (~a_in + 32'd1) : a_in;
  assign w_b_mag   = (w_sgn_in && b_in[31]) ? (~b_in + 32'd1) : b_in;

  // Restoring step: r_acc is the partial remainder, r_a shifts dividend bits out
  // at the top and quotient bits in at the bottom.
  assign w_shift   = {r_acc, r_a[31]};
  assign w_diff    = w_shift - {1'b0, r_b};
  assign w_rem_nxt = w_diff[32] ? w_shift[31:0] : w_diff[31:0];

  assign w_mag_res = r_op[1] ? r_a : r_acc;
  assign w_fixed   = r_neg ? (~w_mag_res + 32'd1) : w_mag_res;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_op     <= 2'd0;
      r_neg    <= 1'b0;
      r_bzero  <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 32'd0;
      r_rd     <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_result <= 32'd0;
      r_rd_out <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= w_a_mag;
            r_b     <= w_b_mag;
            r_acc   <= 32'd0;
            r_rd    <= rd_in;
            r_neg   <= w_sgn_in & (a_in[31] ^ b_in[31]);
            r_bzero <= (b_in == 32'd0);
            r_cnt   <= 6'd0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_op[1]) begin
            r_acc <= w_rem_nxt;
            r_a   <= {r_a[30:0], ~w_diff[32]};
          end else begin
            r_acc <= r_acc + (r_b[0] ? r_a : 32'd0);
            r_a   <= {r_a[30:0], 1'b0};
            r_b   <= {1'b0, r_b[31:1]};
          end
          if (r_cnt == 6'd31) begin
            r_cnt   <= 6'd0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_FIX: begin
          r_result <= (r_op[1] && r_bzero) ? 32'd0 : w_fixed;
          r_rd_out <= r_rd;
          r_done   <= 1'b1;
          r_dbz    <= r_op[1] & r_bzero;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_dbz   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign reg_write   = r_done;
  assign result      = r_result;
  assign rd_out      = r_rd_out;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_dlx_muldiv.sv
// Self-checking bench for dlx_muldiv: directed cases, random ops against an
// arithmetic reference model, start-ignore, back-to-back and reset-abort cases.
module tb_dlx_muldiv;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] a_in  = 32'd0;
  logic [31:0] b_in  = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy;
  logic        done;
  logic        reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  dlx_muldiv dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .rd_in(rd_in),
    .busy(busy), .done(done), .reg_write(reg_write), .result(result),
    .rd_out(rd_out), .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic from the operation definitions.
  function automatic logic [31:0] ref_result(input logic [1:0] f_op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    int          q;
    case (f_op)
      2'd0: begin
        sa = longint'($signed(a)); sb = longint'($signed(b)); sp = sa * sb;
        return sp[31:0];
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return up[31:0];
      end
      2'd2: begin
        if (b == 32'd0) return 32'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      default: return (b == 32'd0) ? 32'd0 : a / b;
    endcase
  endfunction

  // Called at #1 after an edge; returns at #1 after the accepting edge E0.
  task automatic start_op(input logic [1:0] t_op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    op = t_op; a_in = a; b_in = b; rd_in = rd; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("state_calc", {30'd0, dbg_state}, 32'd1);
  endtask

  // mode 0: plain; 1: start pulsed in CALC and in DONE (both ignored);
  // 2: start held from DONE so the next op is accepted on the first IDLE edge.
  task automatic wait_result(input string tag, input logic [31:0] exp_res,
                             input logic [4:0] exp_rd, input logic exp_dbz, input int mode);
    int k = 0;
    while (k < 40 && done !== 1'b1) begin
      @(posedge clock); #1;
      k++;
      if (mode == 1 && k == 10) start = 1'b1;
      if (mode == 1 && k == 11) start = 1'b0;
    end
    check({tag, "_latency"}, k, 33);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_rd_out"}, {27'd0, rd_out}, {27'd0, exp_rd});
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    check({tag, "_reg_write"}, {31'd0, reg_write}, 32'd1);
    if (mode != 0) start = 1'b1;
    @(posedge clock); #1;
    check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_cleared"}, {31'd0, busy}, 32'd0);
    check({tag, "_result_hold"}, result, exp_res);
    if (mode == 1) start = 1'b0;
    if (mode != 0) begin
      @(posedge clock); #1;
      check({tag, "_idle_edge_busy"}, {31'd0, busy}, (mode == 2) ? 32'd1 : 32'd0);
      start = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] t_op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    start_op(t_op, a, b, rd);
    wait_result(tag, ref_result(t_op, a, b), rd, t_op[1] && (b == 32'd0), 0);
  endtask

  initial begin
    logic [1:0]  r_op_v;
    logic [31:0] r_a_v, r_b_v;
    logic [4:0]  r_rd_v;
    int          k;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("idle_no_start", {31'd0, busy}, 32'd0);

    // Directed cases, cross-checked against hand-computed constants
    check("ref_mult_m7x6", ref_result(2'd0, 32'hFFFF_FFF9, 32'd6), 32'hFFFF_FFD6);
    check("ref_div_m100_7", ref_result(2'd2, 32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
    start_op(2'd0, 32'hFFFF_FFF9, 32'd6, 5'd5);
    wait_result("mult_m7x6", 32'hFFFF_FFD6, 5'd5, 1'b0, 0);
    run_op("multu_lowword", 2'd1, 32'h0001_0000, 32'h0001_0000, 5'd3);
    start_op(2'd3, 32'd100, 32'd7, 5'd9);
    wait_result("divu_100_7", 32'd14, 5'd9, 1'b0, 0);
    start_op(2'd2, 32'hFFFF_FF9C, 32'd7, 5'd10);
    wait_result("div_m100_7", 32'hFFFF_FFF2, 5'd10, 1'b0, 0);
    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    wait_result("div_wrap", 32'h8000_0000, 5'd11, 1'b0, 0);
    start_op(2'd3, 32'd5, 32'd0, 5'd12);
    wait_result("divu_by_zero", 32'd0, 5'd12, 1'b1, 0);
    start_op(2'd2, 32'hFFFF_FFF0, 32'd0, 5'd13);
    wait_result("div_by_zero", 32'd0, 5'd13, 1'b1, 0);
    start_op(2'd0, 32'd0, 32'd0, 5'd0);
    wait_result("rd_zero", 32'd0, 5'd0, 1'b0, 0);

    // start in CALC and DONE ignored
    start_op(2'd1, 32'd1234, 32'd5678, 5'd7);
    wait_result("start_ignored", 32'd7006652, 5'd7, 1'b0, 1);

    // Back-to-back: operands changed during CALC must not disturb the latched op
    start_op(2'd2, 32'd1000, 32'hFFFF_FFF6, 5'd14);
    op = 2'd3; a_in = 32'd81; b_in = 32'd9; rd_in = 5'd15;
    wait_result("chain_first", 32'hFFFF_FF9C, 5'd14, 1'b0, 2);
    wait_result("chain_second", 32'd9, 5'd15, 1'b0, 0);

    // Random ops against the reference model
    for (int i = 0; i < 12; i++) begin
      r_op_v = 2'($urandom_range(0, 3));
      r_a_v  = $urandom;
      r_b_v  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      r_rd_v = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d_op%0d", i, r_op_v), r_op_v, r_a_v, r_b_v, r_rd_v);
    end

    // Reset mid-CALC aborts the op
    start_op(2'd0, 32'd77, 32'd88, 5'd20);
    repeat (9) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", {27'd0, rd_out}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) k++;
    end
    check("abort_no_done", k, 0);
    run_op("mult_3x4_after_reset", 2'd0, 32'd3, 32'd4, 5'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dlx_muldiv.md
DLX_MULDIV -- requirements
Module: dlx_muldiv

Interface
REQ-001 The module SHALL have these ports:
- clock  input  1  rising-edge clock, sole clock domain.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- a_in  input  32  operand A (dividend or multiplicand), driven from register-file port A.
- b_in  input  32  operand B (divisor or multiplier), driven from register-file port B.
- rd_in  input  5  destination register index.
- busy  output  1  unit occupied; high from the accepting edge until return to IDLE.
- done  output  1  one-cycle pulse; result, rd_out and div_by_zero are valid while high.
- reg_write  output  1  register-file write enable; identical to done.
- result  output  32  operation result.
- rd_out  output  5  latched destination index, fed to the register-file write port.
- div_by_zero  output  1  high with done when a DIV/DIVU had b = 0.

Function
REQ-002 The FSM SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-003 On an edge in IDLE with start=1, the unit SHALL latch op, a_in, b_in and rd_in, set busy=1, clear the iteration counter and enter CALC (edge E0).
REQ-004 In IDLE with start=0, the unit SHALL hold all state.
REQ-005 start SHALL be ignored in CALC, FIX and DONE; no queuing.
REQ-006 CALC SHALL perform one radix-2 iteration per edge for exactly 32 edges (E1..E32), then enter FIX.
REQ-007 The iteration counter SHALL be 6 bits wide and count 0..31; the transition to FIX SHALL occur on the edge where the counter equals 31.
REQ-008 For signed operations, the unit SHALL convert operands to magnitudes at E0 and record the result sign: XOR of the operand signs for the quotient and for the product.
REQ-009 Multiply SHALL use shift-add on magnitudes; result SHALL be the low 32 bits of the 64-bit product.
REQ-010 Divide SHALL use restoring division on magnitudes; result SHALL be the quotient truncated toward zero; the remainder SHALL be discarded.
REQ-011 At E33, FIX SHALL apply two's-complement negation if the recorded sign is 1, load result, assert done, reg_write and (if applicable) div_by_zero, and enter DONE.
REQ-012 DONE SHALL last exactly one cycle; at E34 the unit SHALL clear done, reg_write and div_by_zero, clear busy and enter IDLE.
REQ-013 Latency SHALL be fixed for every op and operand value: done is high in the cycle after E33, 33 cycles after the accepting edge.
REQ-014 result and rd_out SHALL hold their values after DONE until the next FIX.
REQ-015 For DIV/DIVU with b=0: result SHALL be 32'h00000000 and div_by_zero=1 with done; latency SHALL be unchanged.
REQ-016 For DIV with a=32'h80000000 and b=32'hFFFFFFFF: result SHALL be 32'h80000000 (wrap); div_by_zero=0.
REQ-017 A start asserted in the same cycle that DONE returns to IDLE SHALL NOT be accepted; it is accepted on the first IDLE edge.
REQ-018 rd_out=0 SHALL still produce a reg_write pulse; suppression of writes to r0 is the register file's responsibility.

Reset
REQ-019 While reset=0, the unit SHALL immediately (asynchronously) force state=IDLE, counter=0, busy=0, done=0, reg_write=0, div_by_zero=0, result=0 and rd_out=0.
REQ-020 Reset asserted mid-operation SHALL abort it; no done pulse SHALL follow for the aborted operation.
REQ-021 After reset release, the first accepting edge SHALL require start=1 in IDLE.

Verification
REQ-022 MULT with a=-7 (32'hFFFFFFF9), b=6, rd=5 -> exactly 33 cycles later done=reg_write=1 for 1 cycle, result=32'hFFFFFFD6, rd_out=5, div_by_zero=0.
REQ-023 MULTU with a=32'h0001_0000, b=32'h0001_0000 -> result=32'h00000000 (low word); DIVU with a=100, b=7 -> result=14.
REQ-024 DIV with a=-100, b=7 -> result=-14 (32'hFFFFFFF2); DIV with a=32'h80000000, b=-1 -> result=32'h80000000.
REQ-025 DIVU with a=5, b=0 -> result=0 and div_by_zero=1 together with done, at the same 33-cycle latency.
REQ-026 start pulsed during CALC and during the DONE cycle -> both ignored; exactly one done pulse; busy returns to 0 at E34.
REQ-027 reset driven low at cycle 10 of CALC -> all outputs 0 immediately; no done pulse; a new MULT 3x4 after release -> result=12.
